// File: rtl/config_loader.sv
`default_nettype none
// ============================================================================
// Module   : config_loader
// Purpose  : Streams host words MSB-first into the LE scan chain and releases
//            the fabric once exactly CHAIN_LEN bits have been shifted.
//            Optional CFG_CRC_EN: CRC-8 check word accepted after the image.
// Revision : 1.0  initial release
// ============================================================================
module config_loader #(
  parameter int NUM_LE   = 4,
  parameter int LUT_SIZE = 16,
  parameter int WORD_W   = 8,
  localparam int c_chain_len = NUM_LE * (LUT_SIZE + 1),
  localparam int c_cnt_w     = $clog2(c_chain_len + 1)
) (
  input  logic               clk,
  input  logic               nrst,
  input  logic               en,
  input  logic               start,
  input  logic               abort,
  input  logic [WORD_W-1:0]  s_data,
  input  logic               s_valid,
  output logic               s_ready,
  output logic               cfg_data,
  output logic               cfg_en,
  output logic               le_nrst,
  output logic               le_en,
  output logic               busy,
  output logic               done,
  output logic               error,
  output logic [c_cnt_w-1:0] bit_cnt
);

  localparam int                  c_wcnt_w    = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam logic [c_cnt_w-1:0]  c_last_bit  = c_cnt_w'(c_chain_len - 1);
  localparam logic [c_cnt_w-1:0]  c_full      = c_cnt_w'(c_chain_len);
  localparam logic [c_wcnt_w-1:0] c_word_last = c_wcnt_w'(WORD_W - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_SHIFT = 3'd2,
    S_CHECK = 3'd3,
    S_DONE  = 3'd4,
    S_ERROR = 3'd5
  } state_t;

`ifdef CFG_CRC_EN
  localparam state_t c_end_state = S_CHECK;
`else
  localparam state_t c_end_state = S_DONE;
`endif

  state_t               r_state;
  state_t               w_state_nxt;
  logic [WORD_W-1:0]    r_shreg;
  logic [c_cnt_w-1:0]   r_bit_cnt;
  logic [c_wcnt_w-1:0]  r_word_bits;
  logic                 r_busy;
  logic                 r_done;
  logic                 w_begin;
  logic                 w_load;
  logic                 w_step;

  assign w_begin = en & ~abort & start &
                   ((r_state == S_IDLE) | (r_state == S_DONE) | (r_state == S_ERROR));
  assign w_load  = en & ~abort & s_valid & (r_state == S_LOAD);
  assign w_step  = en & ~abort & (r_state == S_SHIFT);

  assign s_ready  = en & ((r_state == S_LOAD) | (r_state == S_CHECK));
  assign cfg_data = r_shreg[WORD_W-1];
  assign cfg_en   = w_step;
  assign busy     = r_busy;
  assign done     = r_done;
  assign le_nrst  = r_done;
  assign le_en    = r_done;
  assign bit_cnt  = r_bit_cnt;

`ifdef CFG_CRC_EN
  logic       r_crc_err;
  logic [7:0] r_crc;
  logic       w_crc_fb;
  logic       w_check;
  logic       w_crc_ok;

  assign w_crc_fb = r_crc[7] ^ r_shreg[WORD_W-1];
  assign w_check  = en & ~abort & s_valid & (r_state == S_CHECK);
  assign w_crc_ok = (s_data[7:0] == r_crc);
  assign error    = r_crc_err;

  // CRC-8 poly 0x07 over exactly the bits that leave on cfg_data
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_crc <= '0;
    end else if (w_begin) begin
      r_crc <= '0;
    end else if (w_step) begin
      r_crc <= {r_crc[6:0], 1'b0} ^ {5'b0, {3{w_crc_fb}}};
    end
  end
`else
  assign error = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    if (abort) begin
      w_state_nxt = S_IDLE;
    end else if (w_begin) begin
      w_state_nxt = S_LOAD;
    end else if (w_load) begin
      w_state_nxt = S_SHIFT;
    end else if (w_step) begin
      if (r_bit_cnt == c_last_bit) begin
        w_state_nxt = c_end_state;
      end else if (r_word_bits == c_word_last) begin
        w_state_nxt = S_LOAD;
      end
    end
`ifdef CFG_CRC_EN
    else if (w_check) begin
      w_state_nxt = w_crc_ok ? S_DONE : S_ERROR;
    end
`endif
  end

  // Status flags are registered from the next state so le_nrst and busy move together
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state     <= S_IDLE;
      r_shreg     <= '0;
      r_bit_cnt   <= '0;
      r_word_bits <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
`ifdef CFG_CRC_EN
      r_crc_err   <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt == S_LOAD) | (w_state_nxt == S_SHIFT) | (w_state_nxt == S_CHECK);
      r_done  <= (w_state_nxt == S_DONE);
`ifdef CFG_CRC_EN
      r_crc_err <= (w_state_nxt == S_ERROR);
`endif
      if (w_begin) begin
        r_bit_cnt <= '0;
      end
      if (w_load) begin
        r_shreg     <= s_data;
        r_word_bits <= '0;
      end
      if (w_step) begin
        r_shreg     <= {r_shreg[WORD_W-2:0], 1'b0};
        r_word_bits <= r_word_bits + 1'b1;
        if (r_bit_cnt != c_full) begin
          r_bit_cnt <= r_bit_cnt + 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_config_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_config_loader
// Purpose  : Self-checking bench for config_loader (NUM_LE=2, 5-word image).
// Revision : 1.0  initial release
// ============================================================================
module tb_config_loader;

  localparam int NUM_LE    = 2;
  localparam int LUT_SIZE  = 16;
  localparam int WORD_W    = 8;
  localparam int CHAIN_LEN = NUM_LE * (LUT_SIZE + 1);
  localparam int CW        = $clog2(CHAIN_LEN + 1);
  localparam int NUM_WORDS = (CHAIN_LEN + WORD_W - 1) / WORD_W;
  localparam int OW        = 8 + CW;

  logic              clk = 1'b0;
  logic              nrst;
  logic              en;
  logic              start;
  logic              abort;
  logic [WORD_W-1:0] s_data;
  logic              s_valid;
  logic              s_ready;
  logic              cfg_data;
  logic              cfg_en;
  logic              le_nrst;
  logic              le_en;
  logic              busy;
  logic              done;
  logic              error;
  logic [CW-1:0]     bit_cnt;

  always #5 clk = ~clk;

  config_loader #(.NUM_LE(NUM_LE), .LUT_SIZE(LUT_SIZE), .WORD_W(WORD_W)) dut (
    .clk(clk), .nrst(nrst), .en(en), .start(start), .abort(abort),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .cfg_data(cfg_data), .cfg_en(cfg_en), .le_nrst(le_nrst), .le_en(le_en),
    .busy(busy), .done(done), .error(error), .bit_cnt(bit_cnt)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: a load is "fetch a word, drain its bits one per enabled cycle"
  bit         m_loading, m_checking, m_done, m_error;
  int         m_cnt;
  bit         m_q[$];
  logic [7:0] m_crc;

  logic [7:0]    img[NUM_WORDS] = '{8'hA5, 8'h3C, 8'hFF, 8'h00, 8'hC0};
  bit            exp_bits[$];
  bit            got[$];
  logic [7:0]    img_crc;
  logic [OW-1:0] snap;
  bit            hs;
  bit            mono_ok;

  typedef struct {
    logic en, start, abort, valid;
    logic [7:0] data;
    logic ready, cen, cdata, busy, done;
    int cnt;
    bit cnt_dc;
  } vec_t;
  vec_t tbl[19];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] crc_bit(input logic [7:0] c, input bit b);
    logic [7:0] n;
    n = {c[6:0], 1'b0};
    if (c[7] ^ b) n = n ^ 8'h07;
    return n;
  endfunction

  function automatic logic [OW-1:0] pack_outs();
    return {s_ready, cfg_en, cfg_data, le_nrst, le_en, busy, done, error, bit_cnt};
  endfunction

  function automatic logic [OW-1:0] model_expect();
    logic r, ce, cd;
    r  = en && ((m_loading && m_q.size() == 0) || m_checking);
    ce = en && !abort && m_loading && m_q.size() > 0;
    cd = ce ? m_q[0] : 1'b0;
    return {r, ce, cd, m_done, m_done, m_loading || m_checking, m_done, m_error, CW'(m_cnt)};
  endfunction

  task automatic model_reset();
    m_loading = 0; m_checking = 0; m_done = 0; m_error = 0;
    m_cnt = 0; m_crc = 8'h00; m_q.delete();
  endtask

  task automatic model_step();
    bit b;
    if (abort) begin
      m_loading = 0; m_checking = 0; m_done = 0; m_error = 0; m_q.delete();
    end else if (en) begin
      if (m_loading) begin
        if (m_q.size() == 0) begin
          if (s_valid) for (int i = WORD_W - 1; i >= 0; i--) m_q.push_back(s_data[i]);
        end else begin
          b = m_q.pop_front();
          m_cnt++;
          m_crc = crc_bit(m_crc, b);
          if (m_cnt == CHAIN_LEN) begin
            m_q.delete();
            m_loading = 0;
`ifdef CFG_CRC_EN
            m_checking = 1;
`else
            m_done = 1;
`endif
          end
        end
      end else if (m_checking) begin
        if (s_valid) begin
          m_checking = 0;
          if (s_data[7:0] == m_crc) m_done = 1;
          else m_error = 1;
        end
      end else if (start) begin
        m_loading = 1; m_done = 0; m_error = 0; m_cnt = 0; m_crc = 8'h00; m_q.delete();
      end
    end
  endtask

  task automatic drive(input logic e, input logic st, input logic ab, input logic v, input logic [7:0] d);
    en = e; start = st; abort = ab; s_valid = v; s_data = d;
  endtask

  task automatic step();
    logic [OW-1:0] act, exp;
    @(negedge clk);
    act  = pack_outs();
    exp  = model_expect();
    snap = act;
    hs   = exp[OW-1] && s_valid;
    if (cfg_en) got.push_back(cfg_data);
    if (!exp[OW-2]) act[OW-3] = 1'b0;
    chk("model", act, exp);
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic run_load(input bit tog, input int gap_at, input bit noise,
                          input int stop_at, input logic [7:0] crc_xor);
    int gap_left = 0;
    int widx = 0;
    bit gap_used = 0;
    bit ended = 0;
    logic [CW-1:0] prev = '0;
    logic [7:0] w;
    got.delete();
    mono_ok = 1;
    drive(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
    step();
    for (int cyc = 0; cyc < 300; cyc++) begin
      if (stop_at >= 0 && m_loading && m_cnt == stop_at) break;
      if (gap_at >= 0 && !gap_used && m_loading && m_cnt == gap_at && m_q.size() > 0) begin
        gap_left = 3; gap_used = 1;
      end
      w = (widx < NUM_WORDS) ? img[widx] : (img_crc ^ crc_xor);
      drive(gap_left == 0, noise && m_loading, 1'b0, tog ? cyc[0] : 1'b1, w);
      if (gap_left > 0) gap_left--;
      step();
      if (hs) widx++;
      if (snap[CW-1:0] < prev) mono_ok = 0;
      prev = snap[CW-1:0];
      if (!m_loading && !m_checking) begin
        ended = 1;
        break;
      end
    end
    if (stop_at < 0) chk("load_finished", 32'(ended), 1);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic check_image(input string tag);
    int bad = 0;
    chk({tag, "_cfg_en_cycles"}, got.size(), CHAIN_LEN);
    for (int i = 0; i < CHAIN_LEN; i++)
      if (i >= got.size() || got[i] !== exp_bits[i]) bad++;
    chk({tag, "_bits"}, bad, 0);
  endtask

  // One idle cycle, then {done, le_nrst, le_en, error, bit_cnt}
  task automatic check_end(input string tag, input bit ok);
    step();
    chk({tag, "_status"}, {snap[OW-7], snap[OW-4], snap[OW-5], snap[OW-8], snap[CW-1:0]},
        {ok, ok, ok, !ok, CW'(CHAIN_LEN)});
  endtask

  initial begin
    logic [OW-1:0] act, exp;
    tbl[0]  = '{1,1,1,0,8'h00, 0,0,0,0,0, 0,0};
    tbl[1]  = '{1,1,0,0,8'h00, 0,0,0,0,0, 0,0};
    tbl[2]  = '{1,0,0,1,8'hA5, 1,0,0,1,0, 0,0};
    tbl[3]  = '{1,0,0,1,8'h3C, 0,1,1,1,0, 0,0};
    tbl[4]  = '{1,0,0,1,8'h3C, 0,1,0,1,0, 1,0};
    tbl[5]  = '{1,0,0,1,8'h3C, 0,1,1,1,0, 2,0};
    tbl[6]  = '{1,0,0,1,8'h3C, 0,1,0,1,0, 3,0};
    tbl[7]  = '{1,0,0,1,8'h3C, 0,1,0,1,0, 4,0};
    tbl[8]  = '{1,0,0,1,8'h3C, 0,1,1,1,0, 5,0};
    tbl[9]  = '{1,0,0,1,8'h3C, 0,1,0,1,0, 6,0};
    tbl[10] = '{1,0,0,1,8'h3C, 0,1,1,1,0, 7,0};
    tbl[11] = '{1,0,0,1,8'h3C, 1,0,0,1,0, 8,0};
    tbl[12] = '{0,0,0,1,8'h3C, 0,0,0,1,0, 8,0};
    tbl[13] = '{1,0,0,1,8'h3C, 0,1,0,1,0, 8,0};
    tbl[14] = '{1,0,0,1,8'h3C, 0,1,0,1,0, 9,0};
    tbl[15] = '{1,0,0,1,8'h3C, 0,1,1,1,0, 10,0};
    tbl[16] = '{1,0,1,0,8'h00, 0,0,0,1,0, 11,0};
    tbl[17] = '{1,1,0,0,8'h00, 0,0,0,0,0, 0,1};
    tbl[18] = '{1,0,0,0,8'h00, 1,0,0,1,0, 0,0};

    for (int i = 0; i < NUM_WORDS; i++)
      for (int j = WORD_W - 1; j >= 0; j--)
        if (exp_bits.size() < CHAIN_LEN) exp_bits.push_back(img[i][j]);
    img_crc = 8'h00;
    foreach (exp_bits[i]) img_crc = crc_bit(img_crc, exp_bits[i]);

    nrst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    model_reset();
    @(negedge clk);
    chk("reset_outputs", pack_outs(), '0);
    @(posedge clk); #1;
    nrst = 1'b1;

    foreach (tbl[i]) begin
      drive(tbl[i].en, tbl[i].start, tbl[i].abort, tbl[i].valid, tbl[i].data);
      @(negedge clk);
      act = pack_outs();
      exp = {tbl[i].ready, tbl[i].cen, tbl[i].cdata & tbl[i].cen, tbl[i].done, tbl[i].done,
             tbl[i].busy, tbl[i].done, 1'b0, CW'(tbl[i].cnt)};
      if (!tbl[i].cen) act[OW-3] = 1'b0;
      if (tbl[i].cnt_dc) begin
        act[CW-1:0] = '0;
        exp[CW-1:0] = '0;
      end
      chk($sformatf("vec%0d", i), act, exp);
      @(posedge clk); #1;
    end

    nrst = 1'b0; #2; nrst = 1'b1;
    model_reset();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    step();

    // Valid held high
    run_load(0, -1, 0, -1, 8'h00);
    check_image("t1");
    check_end("t1", 1);

    // Valid toggling plus a 3-cycle enable gap mid-word
    run_load(1, 12, 0, -1, 8'h00);
    check_image("t2");
    check_end("t2", 1);

    // Abort at bit 17, then reload from bit 0
    run_load(0, -1, 0, 17, 8'h00);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
    step();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    step();
    chk("t3_after_abort", {snap[OW-2], snap[OW-6], snap[OW-7], snap[OW-4]}, 4'b0000);
    run_load(0, -1, 0, -1, 8'h00);
    check_image("t3");
    check_end("t3", 1);

    // start held during shifting is ignored
    run_load(0, -1, 1, -1, 8'h00);
    chk("t4_cnt_monotonic", 32'(mono_ok), 1);
    check_image("t4");
    check_end("t4", 1);

`ifdef CFG_CRC_EN
    run_load(0, -1, 0, -1, 8'h01);
    check_end("t5_bad_crc", 0);
    run_load(0, -1, 0, -1, 8'h00);
    check_image("t5");
    check_end("t5_recover", 1);
`endif

    // Asynchronous reset in the middle of shifting
    run_load(0, -1, 0, 10, 8'h00);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 8'h00);
    #2 nrst = 1'b0;
    #1 chk("t6_async_reset", pack_outs(), '0);
    model_reset();
    @(posedge clk); #1;
    nrst = 1'b1;
    step();
    run_load(0, -1, 0, -1, 8'h00);
    check_image("t6");
    check_end("t6", 1);

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 9) != 0, $urandom_range(0, 19) == 0, $urandom_range(0, 49) == 0,
            1'($urandom_range(0, 1)), 8'($urandom));
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, vectors %0d", n_vec);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
